ir_sequencer: RTL and testbench
===============================

IR_SEQUENCER -- requirements
Module: ir_sequencer

Interface
REQ-001 Parameter DADDR_W, default 8, data-memory address width.
REQ-002 Parameter RADDR_W, default 4, register-file address width.
REQ-003 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-004 Reset  input  1  reset, asynchronous and active-high.
REQ-005 Hold  input  1  stall; 1 freezes state, all write strobes forced 0.
REQ-006 IR_Data  input  16  current instruction from instruction register.
REQ-007 PC_Clr  output  1  clear program counter.
REQ-008 PC_Up  output  1  increment program counter.
REQ-009 IR_Ld  output  1  load instruction register (drives IR Id enable).
REQ-010 D_Addr  output  DADDR_W  data-memory address.
REQ-011 D_Wr  output  1  data-memory write strobe.
REQ-012 RF_Sel  output  1  RF write source: 1 = memory, 0 = ALU.
REQ-013 RF_W_Addr  output  RADDR_W  RF write address.
REQ-014 RF_W_En  output  1  RF write enable.
REQ-015 RF_Ra_Addr, RF_Rb_Addr  output  RADDR_W each  RF read addresses.
REQ-016 ALU_Sel  output  3  ALU op: 000 pass-A, 001 add, 010 sub.
REQ-017 State_Out  output  4  current state encoding.
REQ-018 Illegal  output  1  illegal-opcode flag (only with macro, REQ-036).

Function
REQ-019 Instruction fields: op=[15:12]; ALU ops Ra=[11:8], Rb=[7:4], Rd=[3:0]; LOAD addr=[11:4], Rd=[3:0]; STORE addr=[7:0], Ra=[11:8].
REQ-020 Opcodes: 0000 NOOP, 0001 STORE, 0010 LOAD, 0011 ADD, 0100 SUB, 0101 HALT; 0110-1111 undefined.
REQ-021 States/encoding: INIT 0, FETCH 1, DECODE 2, NOOP 3, LOAD_A 4, LOAD_B 5, STORE 6, ADD 7, SUB 8, HALT 9.
REQ-022 Transitions: INIT->FETCH; FETCH->DECODE; DECODE->state per opcode; LOAD_A->LOAD_B; NOOP/LOAD_B/STORE/ADD/SUB->FETCH; HALT->HALT.
REQ-023 Undefined opcode in DECODE shall go to NOOP (macro absent).
REQ-024 Outputs shall be Moore decode of state plus IR_Data fields; no output depends on Hold except the strobe gating of REQ-005.
REQ-025 INIT: PC_Clr=1. FETCH: IR_Ld=1, PC_Up=1. All other strobes 0 unless listed.
REQ-026 LOAD_A: D_Addr=addr, RF_Sel=1, RF_W_Addr=Rd. LOAD_B: same plus RF_W_En=1.
REQ-027 STORE: D_Addr=addr, RF_Ra_Addr=Ra, ALU_Sel=000, D_Wr=1.
REQ-028 ADD/SUB: RF_Ra_Addr=Ra, RF_Rb_Addr=Rb, RF_W_Addr=Rd, RF_Sel=0, RF_W_En=1, ALU_Sel=001/010.
REQ-029 Latency: NOOP/STORE/ADD/SUB 3 cycles, LOAD 4 cycles, FETCH to FETCH.
REQ-030 Hold=1 shall keep state unchanged and force PC_Clr, PC_Up, IR_Ld, D_Wr, RF_W_En to 0; resume exactly where frozen.
REQ-031 HALT shall be sticky; only Reset exits it; all strobes 0 in HALT.
REQ-032 Non-strobe address outputs shall be 0 in states that do not define them.

Reset
REQ-033 Reset asserted shall force state to INIT immediately, regardless of Clk, Hold or current state.
REQ-034 Output values while in reset: PC_Clr=1, State_Out=0, Illegal=0, all other outputs 0.
REQ-035 Reset mid-LOAD/STORE shall abort with no RF or memory write asserted after Reset rises.

Configuration
REQ-036 Macro IR_SEQ_ILLEGAL_TRAP_EN defined: undefined opcode in DECODE goes to HALT and sets registered Illegal=1, held until Reset; absent: NOOP per REQ-023, Illegal tied 0.

Structure
REQ-037 Shared package ir_seq_pkg: state enum, opcode constants, ALU_Sel constants, field bit-positions.
REQ-038 One sub-module ir_seq_decode: combinational state/IR_Data to output decode; next-state register stays in ir_sequencer.

Verification
REQ-039 Reset release -> INIT 1 cycle (PC_Clr=1), then FETCH with IR_Ld=1, PC_Up=1.
REQ-040 IR_Data=16'h3123 -> ADD state: Ra=1, Rb=2, Rd=3, ALU_Sel=001, RF_W_En=1, back to FETCH after 3 cycles total.
REQ-041 IR_Data=16'h2AB5 -> LOAD_A then LOAD_B: D_Addr=8'hAB, Rd=5, RF_Sel=1, RF_W_En only in LOAD_B.
REQ-042 IR_Data=16'h1700 with Hold=1 for 3 cycles in STORE -> D_Wr=0 while held, D_Wr=1 one cycle after release, D_Addr=8'h00.
REQ-043 IR_Data=16'h5000 -> HALT persists 10 cycles with IR_Ld=0; Reset pulse -> INIT.
REQ-044 IR_Data=16'hF000 -> NOOP (macro absent) or HALT with Illegal=1 (macro defined).

Source files
------------

// File: rtl/ir_seq_pkg.sv
// Shared types and constants for the instruction-register sequencer:
// state encoding, opcodes, ALU selects and instruction field positions.
package ir_seq_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  // LOAD and STORE place their 8-bit address in different fields
  localparam int OP_HI      = 15;
  localparam int OP_LO      = 12;
  localparam int RA_HI      = 11;
  localparam int RA_LO      = 8;
  localparam int RB_HI      = 7;
  localparam int RB_LO      = 4;
  localparam int RD_HI      = 3;
  localparam int RD_LO      = 0;
  localparam int LD_ADDR_HI = 11;
  localparam int LD_ADDR_LO = 4;
  localparam int ST_ADDR_HI = 7;
  localparam int ST_ADDR_LO = 0;

endpackage

// File: rtl/ir_sequencer_if.sv
// Control bus between the sequencer (master) and the datapath it steers (slave).
interface ir_sequencer_if #(
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4
);
  logic               Hold;
  logic [15:0]        IR_Data;
  logic               PC_Clr;
  logic               PC_Up;
  logic               IR_Ld;
  logic [DADDR_W-1:0] D_Addr;
  logic               D_Wr;
  logic               RF_Sel;
  logic [RADDR_W-1:0] RF_W_Addr;
  logic               RF_W_En;
  logic [RADDR_W-1:0] RF_Ra_Addr;
  logic [RADDR_W-1:0] RF_Rb_Addr;
  logic [2:0]         ALU_Sel;
  logic [3:0]         State_Out;
  logic               Illegal;

  modport master (
    input  Hold, IR_Data,
    output PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_Sel, RF_W_Addr, RF_W_En,
           RF_Ra_Addr, RF_Rb_Addr, ALU_Sel, State_Out, Illegal
  );

  modport slave (
    output Hold, IR_Data,
    input  PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_Sel, RF_W_Addr, RF_W_En,
           RF_Ra_Addr, RF_Rb_Addr, ALU_Sel, State_Out, Illegal
  );
endinterface

// File: rtl/ir_seq_decode.sv
// Moore output decode: current state plus instruction operand fields to
// datapath controls; hold gates every write/step strobe to 0.
module ir_seq_decode
  import ir_seq_pkg::*;
#(
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4
) (
  input  state_t             state,
  input  logic [11:0]        ir,
  input  logic               hold,
  output logic               pc_clr,
  output logic               pc_up,
  output logic               ir_ld,
  output logic [DADDR_W-1:0] d_addr,
  output logic               d_wr,
  output logic               rf_sel,
  output logic [RADDR_W-1:0] rf_w_addr,
  output logic               rf_w_en,
  output logic [RADDR_W-1:0] rf_ra_addr,
  output logic [RADDR_W-1:0] rf_rb_addr,
  output logic [2:0]         alu_sel
);

  always_comb begin
    pc_clr     = 1'b0;
    pc_up      = 1'b0;
    ir_ld      = 1'b0;
    d_addr     = '0;
    d_wr       = 1'b0;
    rf_sel     = 1'b0;
    rf_w_addr  = '0;
    rf_w_en    = 1'b0;
    rf_ra_addr = '0;
    rf_rb_addr = '0;
    alu_sel    = ALU_PASS;
    case (state)
      S_INIT:  pc_clr = 1'b1;
      S_FETCH: begin
        ir_ld = 1'b1;
        pc_up = 1'b1;
      end
      S_LOAD_A, S_LOAD_B: begin
        d_addr    = DADDR_W'(ir[LD_ADDR_HI:LD_ADDR_LO]);
        rf_sel    = 1'b1;
        rf_w_addr = RADDR_W'(ir[RD_HI:RD_LO]);
        rf_w_en   = (state == S_LOAD_B);
      end
      S_STORE: begin
        d_addr     = DADDR_W'(ir[ST_ADDR_HI:ST_ADDR_LO]);
        rf_ra_addr = RADDR_W'(ir[RA_HI:RA_LO]);
        alu_sel    = ALU_PASS;
        d_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        rf_ra_addr = RADDR_W'(ir[RA_HI:RA_LO]);
        rf_rb_addr = RADDR_W'(ir[RB_HI:RB_LO]);
        rf_w_addr  = RADDR_W'(ir[RD_HI:RD_LO]);
        rf_w_en    = 1'b1;
        alu_sel    = (state == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
    if (hold) begin
      pc_clr  = 1'b0;
      pc_up   = 1'b0;
      ir_ld   = 1'b0;
      d_wr    = 1'b0;
      rf_w_en = 1'b0;
    end
  end

endmodule

// File: rtl/ir_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/execute state register.
// Optional trap on undefined opcodes when IR_SEQ_ILLEGAL_TRAP_EN is defined.
module ir_sequencer
  import ir_seq_pkg::*;
#(
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4
) (
  input logic            Clk,
  input logic            Reset,
  ir_sequencer_if.master bus
);

  state_t     state;
  logic [3:0] op;
  logic       hold_eff;

  assign op = bus.IR_Data[OP_HI:OP_LO];
  // Reset dominates Hold so PC_Clr is visible during reset even when stalled
  assign hold_eff = bus.Hold & ~Reset;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_INIT;
    end else if (!bus.Hold) begin
      case (state)
        S_INIT:   state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_NOOP:  state <= S_NOOP;
            OP_STORE: state <= S_STORE;
            OP_LOAD:  state <= S_LOAD_A;
            OP_ADD:   state <= S_ADD;
            OP_SUB:   state <= S_SUB;
            OP_HALT:  state <= S_HALT;
`ifdef IR_SEQ_ILLEGAL_TRAP_EN
            default:  state <= S_HALT;
`else
            default:  state <= S_NOOP;
`endif
          endcase
        end
        S_LOAD_A: state <= S_LOAD_B;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;
      endcase
    end
  end

`ifdef IR_SEQ_ILLEGAL_TRAP_EN
  logic illegal;

  // Sticky until reset; HALT itself is never left without reset either
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      illegal <= 1'b0;
    end else if (!bus.Hold && state == S_DECODE && op > OP_HALT) begin
      illegal <= 1'b1;
    end
  end

  assign bus.Illegal = illegal;
`else
  assign bus.Illegal = 1'b0;
`endif

  assign bus.State_Out = state;

  ir_seq_decode #(
    .DADDR_W(DADDR_W),
    .RADDR_W(RADDR_W)
  ) u_decode (
    .state      (state),
    .ir         (bus.IR_Data[11:0]),
    .hold       (hold_eff),
    .pc_clr     (bus.PC_Clr),
    .pc_up      (bus.PC_Up),
    .ir_ld      (bus.IR_Ld),
    .d_addr     (bus.D_Addr),
    .d_wr       (bus.D_Wr),
    .rf_sel     (bus.RF_Sel),
    .rf_w_addr  (bus.RF_W_Addr),
    .rf_w_en    (bus.RF_W_En),
    .rf_ra_addr (bus.RF_Ra_Addr),
    .rf_rb_addr (bus.RF_Rb_Addr),
    .alu_sel    (bus.ALU_Sel)
  );

endmodule

// File: tb/tb_ir_sequencer.sv
// Bench for ir_sequencer: directed scenarios then random instructions/stalls,
// checked against an instruction-timeline reference model.
module tb_ir_sequencer;

  logic clk;
  logic rst;

  ir_sequencer_if #(.DADDR_W(8), .RADDR_W(4)) bus ();

  ir_sequencer #(.DADDR_W(8), .RADDR_W(4)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  int   cur;          // state code the model expects right now
  int   plan[$];      // upcoming state codes of the instruction in flight
  logic ill;

  // Expected outputs written straight from the output table of each state
  function automatic logic [33:0] expect_out(int st, logic [15:0] ir, logic hold, logic illf);
    logic       pcc, pcu, irl, dwr, sel, wen;
    logic [7:0] da;
    logic [3:0] wa, ra, rb, s4;
    logic [2:0] alu;
    {pcc, pcu, irl, dwr, sel, wen} = 6'b0;
    da = 8'h00; wa = 4'h0; ra = 4'h0; rb = 4'h0; alu = 3'b000;
    if (st == 0) pcc = 1'b1;
    if (st == 1) begin irl = 1'b1; pcu = 1'b1; end
    if (st == 4 || st == 5) begin
      da = ir[11:4]; sel = 1'b1; wa = ir[3:0]; wen = (st == 5);
    end
    if (st == 6) begin da = ir[7:0]; ra = ir[11:8]; dwr = 1'b1; end
    if (st == 7 || st == 8) begin
      ra = ir[11:8]; rb = ir[7:4]; wa = ir[3:0]; wen = 1'b1;
      alu = (st == 7) ? 3'b001 : 3'b010;
    end
    if (hold) {pcc, pcu, irl, dwr, wen} = 5'b0;
    s4 = 4'(st);
    return {pcc, pcu, irl, da, dwr, sel, wa, wen, ra, rb, alu, s4, illf};
  endfunction

  task automatic check(input string tag);
    logic [33:0] obs, exp;
    obs = {bus.PC_Clr, bus.PC_Up, bus.IR_Ld, bus.D_Addr, bus.D_Wr, bus.RF_Sel,
           bus.RF_W_Addr, bus.RF_W_En, bus.RF_Ra_Addr, bus.RF_Rb_Addr,
           bus.ALU_Sel, bus.State_Out, bus.Illegal};
    exp = expect_out(cur, bus.IR_Data, bus.Hold & ~rst, ill);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s state=%0d observed=%h expected=%h", tag, cur, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur = 0;
    plan = '{1, 2};
    ill = 1'b0;
  endtask

  // One clock edge of the model: DECODE schedules the instruction's body
  task automatic advance(input logic [15:0] ir);
    if (cur == 9) return;
    if (cur == 2) begin
      plan.delete();
      case (ir[15:12])
        4'd0: plan = '{3};
        4'd1: plan = '{6};
        4'd2: plan = '{4, 5};
        4'd3: plan = '{7};
        4'd4: plan = '{8};
        4'd5: plan = '{9};
        default: begin
`ifdef IR_SEQ_ILLEGAL_TRAP_EN
          plan = '{9};
          ill = 1'b1;
`else
          plan = '{3};
`endif
        end
      endcase
      if (plan[0] != 9) begin
        plan.push_back(1);
        plan.push_back(2);
      end
    end
    cur = plan.pop_front();
  endtask

  // Called at a negedge; returns at the following negedge
  task automatic step(input logic h, input logic [15:0] ir, input string tag);
    bus.Hold = h;
    bus.IR_Data = ir;
    #1;
    check(tag);
    @(posedge clk);
    if (!h) advance(ir);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges, held across one posedge
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check(tag);
    @(posedge clk);
    #1;
    check({tag, "_held"});
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int halt_cnt;
    logic [15:0] rir;
    logic rh;
    rst = 1'b1;
    bus.Hold = 1'b0;
    bus.IR_Data = 16'h0000;
    model_reset();
    @(negedge clk);
    check("in_reset");
    bus.Hold = 1'b1;
    #1;
    check("in_reset_hold");
    bus.Hold = 1'b0;
    rst = 1'b0;

    // INIT, then ADD 3123 from FETCH
    step(0, 16'h3123, "init");
    step(0, 16'h3123, "add_fetch");
    step(0, 16'h3123, "add_decode");
    step(0, 16'h3123, "add_exec");
    // LOAD 2AB5: two execute cycles, write only in the second
    step(0, 16'h2AB5, "load_fetch");
    step(0, 16'h2AB5, "load_decode");
    step(0, 16'h2AB5, "load_a");
    step(0, 16'h2AB5, "load_b");
    // STORE 1700 stalled three cycles in STORE
    step(0, 16'h1700, "store_fetch");
    step(0, 16'h1700, "store_decode");
    step(1, 16'h1700, "store_hold1");
    step(1, 16'h1700, "store_hold2");
    step(1, 16'h1700, "store_hold3");
    step(0, 16'h1700, "store_exec");
    // SUB and a stall in FETCH
    step(1, 16'h4A5C, "sub_fetch_hold");
    step(0, 16'h4A5C, "sub_fetch");
    step(0, 16'h4A5C, "sub_decode");
    step(0, 16'h4A5C, "sub_exec");
    // Undefined opcode
    step(0, 16'hF000, "undef_fetch");
    step(0, 16'hF000, "undef_decode");
    step(0, 16'hF000, "undef_exec");
    step(0, 16'hF000, "undef_after");
    do_reset("reset_after_undef");
    // HALT is sticky for ten cycles, then reset returns to INIT
    step(0, 16'h5000, "init2");
    step(0, 16'h5000, "halt_fetch");
    step(0, 16'h5000, "halt_decode");
    for (int i = 0; i < 10; i++) step(0, 16'h5000, "halt_sticky");
    do_reset("reset_from_halt");
    // Abort a LOAD mid-way: no write strobes once reset rises
    step(0, 16'h2C37, "init3");
    step(0, 16'h2C37, "abort_fetch");
    step(0, 16'h2C37, "abort_decode");
    step(0, 16'h2C37, "abort_load_a");
    do_reset("reset_mid_load");

    // Random instructions, stalls and occasional resets
    halt_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      rir = 16'($urandom);
      if (rir[15:12] == 4'd5 && $urandom_range(0, 3) != 0) rir[15:12] = 4'd3;
      rh = ($urandom_range(0, 3) == 0);
      step(rh, rir, "random");
      halt_cnt = (cur == 9) ? halt_cnt + 1 : 0;
      if (halt_cnt > 3 || $urandom_range(0, 49) == 0) begin
        do_reset("random_reset");
        halt_cnt = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
